// File: rtl/alu_seq_if.sv
// Request/result bus for alu_seq: operation handshake, operands, result and flag outputs.
interface alu_seq_if #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4
);
  logic             i_valid;
  logic             o_ready;
  logic [OP_W-1:0]  op_code;
  logic [WIDTH-1:0] i_1;
  logic [WIDTH-1:0] i_2;
  logic             flag_we;
  logic [WIDTH-1:0] o_main;
  logic             o_valid;
  logic             carry_out;
  logic             zero_out;
  logic             neg_out;
  logic             ovf_out;

  modport master (
    output i_valid, op_code, i_1, i_2, flag_we,
    input  o_ready, o_main, o_valid, carry_out, zero_out, neg_out, ovf_out
  );

  modport slave (
    input  i_valid, op_code, i_1, i_2, flag_we,
    output o_ready, o_main, o_valid, carry_out, zero_out, neg_out, ovf_out
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with persistent C/Z/N/V flags and valid/ready handshake.
// Define ALU_MUL_EN to add the multi-cycle shift-add multiplier (opcode 11).
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);
  localparam int MSB = WIDTH - 1;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_NOT = OP_W'(5);
  localparam logic [OP_W-1:0] OP_ADC = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SBC = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SHL = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SHR = OP_W'(10);

  logic [WIDTH-1:0] main_q, main_d;
  logic             valid_q, valid_d;
  logic             c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;

  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v, cin;
  logic [WIDTH:0]   ext;
  logic             ready, accept, is_mul;

`ifdef ALU_MUL_EN
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(11);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t             state_q, state_d;
  logic               ready_q, ready_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fwe_q, fwe_d;
  logic [WIDTH:0]     mul_sum;

  assign ready   = ready_q;
  assign is_mul  = (bus.op_code == OP_MUL);
  // Upper half accumulates the multiplicand; lower half shifts out multiplier bits.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
`else
  assign ready  = 1'b1;
  assign is_mul = 1'b0;
`endif

  assign accept = bus.i_valid && ready;
  assign cin    = ((bus.op_code == OP_ADC) || (bus.op_code == OP_SBC)) && c_q;

  always_comb begin
    ext   = '0;
    alu_r = bus.i_2;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.op_code)
      OP_ADD, OP_ADC: begin
        ext   = {1'b0, bus.i_1} + {1'b0, bus.i_2} + {{WIDTH{1'b0}}, cin};
        alu_r = ext[MSB:0];
        alu_c = ext[WIDTH];
        alu_v = (bus.i_1[MSB] == bus.i_2[MSB]) && (alu_r[MSB] != bus.i_1[MSB]);
      end
      OP_SUB, OP_SBC: begin
        // The extra top bit of the difference is the borrow.
        ext   = {1'b0, bus.i_1} - {1'b0, bus.i_2} - {{WIDTH{1'b0}}, cin};
        alu_r = ext[MSB:0];
        alu_c = ext[WIDTH];
        alu_v = (bus.i_1[MSB] != bus.i_2[MSB]) && (alu_r[MSB] != bus.i_1[MSB]);
      end
      OP_AND: alu_r = bus.i_1 & bus.i_2;
      OP_OR:  alu_r = bus.i_1 | bus.i_2;
      OP_XOR: alu_r = bus.i_1 ^ bus.i_2;
      OP_NOT: alu_r = ~bus.i_1;
      OP_SHL: begin
        alu_r = {bus.i_1[MSB-1:0], 1'b0};
        alu_c = bus.i_1[MSB];
      end
      OP_SHR: begin
        alu_r = {1'b0, bus.i_1[MSB:1]};
        alu_c = bus.i_1[0];
      end
      default: alu_r = bus.i_2;
    endcase
  end

  always_comb begin
    main_d  = main_q;
    valid_d = 1'b0;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    if (accept && !is_mul) begin
      main_d  = alu_r;
      valid_d = 1'b1;
      if (bus.flag_we) begin
        c_d = alu_c;
        z_d = (alu_r == '0);
        n_d = alu_r[MSB];
        v_d = alu_v;
      end
    end
`ifdef ALU_MUL_EN
    state_d = state_q;
    ready_d = ready_q;
    a_d     = a_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    fwe_d   = fwe_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_mul) begin
          state_d = ST_MUL;
          ready_d = 1'b0;
          a_d     = bus.i_1;
          acc_d   = {{WIDTH{1'b0}}, bus.i_2};
          cnt_d   = CNT_W'(WIDTH - 1);
          fwe_d   = bus.flag_we;
        end
      end
      ST_MUL: begin
        acc_d = {mul_sum, acc_q[MSB:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          main_d  = acc_d[MSB:0];
          valid_d = 1'b1;
          if (fwe_q) begin
            c_d = |acc_d[2*WIDTH-1:WIDTH];
            z_d = (acc_d[MSB:0] == '0);
            n_d = acc_d[MSB];
            v_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q  <= '0;
      valid_q <= 1'b0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
`ifdef ALU_MUL_EN
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      a_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      fwe_q   <= 1'b0;
`endif
    end else begin
      main_q  <= main_d;
      valid_q <= valid_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
`ifdef ALU_MUL_EN
      state_q <= state_d;
      ready_q <= ready_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      fwe_q   <= fwe_d;
`endif
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_main    = main_q;
  assign bus.o_valid   = valid_q;
  assign bus.carry_out = c_q;
  assign bus.zero_out  = z_q;
  assign bus.neg_out   = n_q;
  assign bus.ovf_out   = v_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8); MUL expectations follow ALU_MUL_EN.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_seq_if #(.WIDTH(8), .OP_W(4)) bus ();

  alu_seq #(.WIDTH(8), .OP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [7:0] main, input logic valid);
    chk({tag, "_main"}, 16'(bus.o_main), 16'(main));
    chk({tag, "_valid"}, 16'(bus.o_valid), 16'(valid));
  endtask

  task automatic chk_flags(input string tag, input logic c, input logic z, input logic n, input logic v);
    chk({tag, "_C"}, 16'(bus.carry_out), 16'(c));
    chk({tag, "_Z"}, 16'(bus.zero_out), 16'(z));
    chk({tag, "_N"}, 16'(bus.neg_out), 16'(n));
    chk({tag, "_V"}, 16'(bus.ovf_out), 16'(v));
  endtask

  // Present one op for a single cycle; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic fwe);
    bus.op_code = op;
    bus.i_1     = a;
    bus.i_2     = b;
    bus.flag_we = fwe;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.op_code = '0;
    bus.i_1     = '0;
    bus.i_2     = '0;
    bus.flag_we = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", 16'(bus.o_ready), 16'h1);
    chk_res("reset", 8'h00, 1'b0);
    chk_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);

    issue(4'd0, 8'hF0, 8'h20, 1'b1);
    chk_res("add_f0_20", 8'h10, 1'b1);
    chk_flags("add_f0_20", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_res("idle_hold", 8'h10, 1'b0);

    issue(4'd0, 8'hFF, 8'h01, 1'b1);
    chk_res("add_ff_01", 8'h00, 1'b1);
    chk_flags("add_ff_01", 1'b1, 1'b1, 1'b0, 1'b0);
    issue(4'd7, 8'h00, 8'h00, 1'b1);
    chk_res("adc_cin1", 8'h01, 1'b1);
    chk_flags("adc_cin1", 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd7, 8'h00, 8'h00, 1'b0);
    chk_res("adc_nowe", 8'h00, 1'b1);
    chk_flags("adc_nowe", 1'b0, 1'b0, 1'b0, 1'b0);

    issue(4'd1, 8'h05, 8'h07, 1'b1);
    chk_res("sub_05_07", 8'hFE, 1'b1);
    chk_flags("sub_05_07", 1'b1, 1'b0, 1'b1, 1'b0);
    issue(4'd8, 8'h10, 8'h05, 1'b1);
    chk_res("sbc_10_05", 8'h0A, 1'b1);
    chk_flags("sbc_10_05", 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd1, 8'h80, 8'h01, 1'b1);
    chk_res("sub_80_01", 8'h7F, 1'b1);
    chk_flags("sub_80_01", 1'b0, 1'b0, 1'b0, 1'b1);

    issue(4'd2, 8'hF0, 8'h3C, 1'b1);
    chk_res("and", 8'h30, 1'b1);
    chk_flags("and", 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd4, 8'hAA, 8'hAA, 1'b1);
    chk_res("xor", 8'h00, 1'b1);
    chk_flags("xor", 1'b0, 1'b1, 1'b0, 1'b0);
    issue(4'd9, 8'hC0, 8'h00, 1'b1);
    chk_res("shl_c0", 8'h80, 1'b1);
    chk_flags("shl_c0", 1'b1, 1'b0, 1'b1, 1'b0);
    issue(4'd3, 8'h0F, 8'h30, 1'b1);
    chk_res("or", 8'h3F, 1'b1);
    chk_flags("or", 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd5, 8'h0F, 8'h00, 1'b1);
    chk_res("not", 8'hF0, 1'b1);
    chk_flags("not", 1'b0, 1'b0, 1'b1, 1'b0);
    issue(4'd6, 8'h11, 8'h5A, 1'b1);
    chk_res("load", 8'h5A, 1'b1);
    issue(4'd14, 8'h11, 8'h00, 1'b1);
    chk_res("op14_load", 8'h00, 1'b1);
    chk_flags("op14_load", 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef ALU_MUL_EN
    issue(4'd11, 8'h12, 8'h34, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy_ready", 16'(bus.o_ready), 16'h0);
      chk("mul_busy_valid", 16'(bus.o_valid), 16'h0);
      bus.op_code = 4'd0;
      bus.i_1     = 8'($urandom);
      bus.i_2     = 8'($urandom);
      bus.flag_we = 1'b0;
      bus.i_valid = (i < 7);
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    chk("mul_done_ready", 16'(bus.o_ready), 16'h1);
    chk_res("mul_12_34", 8'hA8, 1'b1);
    chk_flags("mul_12_34", 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_res("mul_after", 8'hA8, 1'b0);
`else
    issue(4'd11, 8'h12, 8'h34, 1'b1);
    chk("op11_ready", 16'(bus.o_ready), 16'h1);
    chk_res("op11_load", 8'h34, 1'b1);
    chk_flags("op11_load", 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    issue(4'd11, 8'h12, 8'h34, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", 16'(bus.o_ready), 16'h1);
    chk_res("midrst", 8'h00, 1'b0);
    chk_flags("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", 16'(bus.o_valid), 16'h0);
    end

    bus.op_code = 4'd9;
    bus.i_1     = 8'h81;
    bus.i_2     = 8'h00;
    bus.flag_we = 1'b1;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.op_code = 4'd10;
    bus.i_1     = 8'h01;
    chk("b2b_ready", 16'(bus.o_ready), 16'h1);
    chk_res("b2b_shl", 8'h02, 1'b1);
    chk_flags("b2b_shl", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.i_valid = 1'b0;
    chk_res("b2b_shr", 8'h00, 1'b1);
    chk_flags("b2b_shr", 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_res("b2b_after", 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
